// File: rtl/param_memory_if.sv
// Request/response bundle for param_memory: requests from the master,
// registered read data and status back from the memory.
interface param_memory_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
);
    logic              ren;
    logic              wen;
    logic              clr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              rvalid;
    logic              ready;
    logic              coll;

    modport master (
        output ren, wen, clr, addr, din,
        input  dout, rvalid, ready, coll
    );

    modport slave (
        input  ren, wen, clr, addr, din,
        output dout, rvalid, ready, coll
    );
endinterface

// File: rtl/param_memory.sv
// Single-port word memory that zero-sweeps itself after reset or clr before serving requests.
// Define MEM_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module param_memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    param_memory_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_go;

    logic [DATA_W-1:0] dout_p0;
    logic              vld_p0;
    logic              coll_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep ends on the terminal count; cnt is parked at 0 so it never wraps into a second sweep.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = bus.addr;
        mem_wdata = bus.din;
        rd_go     = 1'b0;
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (bus.clr) begin
                    cnt_d = '0;
                end else if (cnt_q == '1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (bus.clr) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else begin
                    rd_go  = bus.ren;
                    mem_we = bus.wen && !bus.ren;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Stage p0: registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_p0 <= '0;
            vld_p0  <= 1'b0;
            coll_p0 <= 1'b0;
        end else if (rd_go) begin
            dout_p0 <= mem[bus.addr];
            vld_p0  <= 1'b1;
            coll_p0 <= bus.wen;
        end else begin
            dout_p0 <= '0;
            vld_p0  <= 1'b0;
            coll_p0 <= 1'b0;
        end
    end

`ifdef MEM_OUTREG_EN
    logic [DATA_W-1:0] dout_p1;
    logic              vld_p1;
    logic              coll_p1;

    // Stage p1: extra output register, flushed on the edge that enters INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
            coll_p1 <= 1'b0;
        end else if (state_d == INIT) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
            coll_p1 <= 1'b0;
        end else begin
            dout_p1 <= dout_p0;
            vld_p1  <= vld_p0;
            coll_p1 <= coll_p0;
        end
    end

    assign bus.dout   = dout_p1;
    assign bus.rvalid = vld_p1;
    assign bus.coll   = coll_p1;
`else
    assign bus.dout   = dout_p0;
    assign bus.rvalid = vld_p0;
    assign bus.coll   = coll_p0;
`endif

    assign bus.ready = (state_q == IDLE);
endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory: init sweep length, read/write, collision, clr and async reset.
module tb_param_memory;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 7;
`ifdef MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    param_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    param_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.ready && n < 400) begin
            step();
            n++;
        end
        chk(tag, n, 128);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wen  = 1'b1;
        bus.addr = a;
        bus.din  = d;
        step();
        bus.wen  = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        bus.ren  = 1'b1;
        bus.addr = a;
        step();
        bus.ren  = 1'b0;
        for (int i = 1; i < LAT; i++) step();
        chk({tag, "_dout"}, bus.dout, exp);
        chk({tag, "_rvalid"}, bus.rvalid, 1);
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        rst_n    = 1'b0;
        bus.ren  = 1'b0;
        bus.wen  = 1'b0;
        bus.clr  = 1'b0;
        bus.addr = '0;
        bus.din  = '0;
        #3;
        chk("rst_ready", bus.ready, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_coll", bus.coll, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("init_cycles");

        do_read("rd55", 7'h55, 8'h00);

        do_write(7'h10, 8'hA5);
        do_read("raw10", 7'h10, 8'hA5);

        // Read+write together: read wins, write is dropped, coll pulses once
        bus.ren  = 1'b1;
        bus.wen  = 1'b1;
        bus.addr = 7'h10;
        bus.din  = 8'h3C;
        step();
        bus.ren  = 1'b0;
        bus.wen  = 1'b0;
        for (int i = 1; i < LAT; i++) step();
        chk("coll_pulse", bus.coll, 1);
        chk("coll_dout", bus.dout, 8'hA5);
        chk("coll_rvalid", bus.rvalid, 1);
        step();
        chk("coll_clear", bus.coll, 0);
        do_read("after_coll", 7'h10, 8'hA5);

        step();
        step();
        chk("idle_dout", bus.dout, 0);
        chk("idle_rvalid", bus.rvalid, 0);

        do_write(7'h20, 8'h5A);
        do_write(7'h7F, 8'hFF);
        do_read("rd20", 7'h20, 8'h5A);
        do_read("rd7f", 7'h7F, 8'hFF);
        do_read("rd00", 7'h00, 8'h00);

        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk("clr_ready", bus.ready, 0);
        wait_ready("clr_cycles");
        do_read("clr10", 7'h10, 8'h00);
        do_read("clr7f", 7'h7F, 8'h00);

        // Async reset landing between edges while read data is on dout
        do_write(7'h7F, 8'hC3);
        do_read("pre_rst", 7'h7F, 8'hC3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", bus.dout, 0);
        chk("arst_rvalid", bus.rvalid, 0);
        chk("arst_ready", bus.ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reinit_cycles");
        do_read("reinit7f", 7'h7F, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 7, address width in bits; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ren  input  1  read request for the current cycle.
REQ-006 SHALL have port wen  input  1  write request for the current cycle.
REQ-007 SHALL have port addr  input  ADDR_W  word address for read or write.
REQ-008 SHALL have port din  input  DATA_W  write data.
REQ-009 SHALL have port clr  input  1  request to re-zero the whole array.
REQ-010 SHALL have port dout  output  DATA_W  registered read data.
REQ-011 SHALL have port rvalid  output  1  dout carries valid read data.
REQ-012 SHALL have port ready  output  1  array initialised; requests accepted.
REQ-013 SHALL have port coll  output  1  one-cycle pulse: simultaneous ren and wen, write dropped.

Function
REQ-014 SHALL implement a two-state FSM: INIT (sweeping zeros) and IDLE (serving requests).
REQ-015 INIT SHALL write 0 to mem[cnt] each cycle, cnt from 0 up to DEPTH-1, then enter IDLE next cycle; INIT lasts exactly DEPTH cycles.
REQ-016 ready SHALL be 1 only in IDLE and SHALL rise on the edge the FSM enters IDLE.
REQ-017 In INIT, ren/wen SHALL be ignored; dout=0, rvalid=0, coll=0.
REQ-018 clr in IDLE SHALL move the FSM to INIT with cnt=0 on the next edge; clr in INIT SHALL restart the sweep at cnt=0.
REQ-019 clr SHALL take priority over ren/wen in the same cycle; the request SHALL be dropped.
REQ-020 In IDLE, wen=1 with ren=0 SHALL write din to mem[addr] at the edge.
REQ-021 In IDLE, ren=1 SHALL register mem[addr] to dout with rvalid=1, latency 1 cycle (base build).
REQ-022 ren=1 with wen=1 SHALL perform the read only, drop the write, and pulse coll=1 aligned with rvalid.
REQ-023 ren=0 in IDLE SHALL drive dout=0 and rvalid=0 on the following cycle.
REQ-024 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-025 cnt SHALL be ADDR_W bits wide; the terminal count DEPTH-1 SHALL not wrap back into INIT.

Reset
REQ-026 rst_n=0 SHALL immediately force dout=0, rvalid=0, coll=0, ready=0, cnt=0, state INIT, independent of clk.
REQ-027 After rst_n rises, the first INIT write SHALL occur at the first rising clk edge.
REQ-028 Reset asserted mid-read or mid-sweep SHALL abort the operation; array contents are undefined until INIT completes.

Configuration
REQ-029 Macro MEM_OUTREG_EN, when defined, SHALL add one output register stage to dout, rvalid and coll, making read latency 2 cycles.
REQ-030 With MEM_OUTREG_EN, the extra stage SHALL reset to 0 and SHALL output 0 during INIT; without it, latency is 1 and no extra stage exists.

Verification (DATA_W=8, ADDR_W=7, DEPTH=128)
REQ-031 Release rst_n -> ready=0 for exactly 128 cycles then 1; then ren, addr=0x55 -> dout=0x00, rvalid=1 after the configured latency.
REQ-032 wen, addr=0x10, din=0xA5; next cycle ren, addr=0x10 -> dout=0xA5, rvalid=1 after 1 cycle (2 with MEM_OUTREG_EN).
REQ-033 ren=wen=1, addr=0x10, din=0x3C -> coll=1 for one cycle, dout=0xA5; later read of 0x10 -> 0xA5.
REQ-034 Idle cycle with ren=0 -> dout=0x00, rvalid=0.
REQ-035 clr pulse in IDLE -> ready=0 for 128 cycles; then read 0x10 -> 0x00.
REQ-036 rst_n driven low between clk edges during a read -> dout=0x00, rvalid=0, ready=0 before the next edge.
